// File: rtl/wb_sdram_emulator.sv
// Wishbone classic responder emulating the SDRAM controller on top of on-chip RAM.
// Latency: ack_o/err_o pulse in the cycle after edge N+2+WAIT_STATES for a request accepted at edge N.
// Backpressure: requests wait on the bus during refresh stalls; HOLD blocks re-acceptance until stb_i falls.
module wb_sdram_emulator #(
    parameter int MEM_AW         = 10,
    parameter int WAIT_STATES    = 2,
    parameter int REFRESH_PERIOD = 1040,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [21:0] addr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [RW-1:0] RP_LAST = RW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM,
        ST_HOLD,
        ST_REFRESH
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    tmr, tmr_nxt;
    logic [21:0]   addr_q;
    logic [31:0]   wdat_q;
    logic          we_q;
    logic          accept;
    logic          rfsh_done;
    logic          rfsh_pend;
    logic [RW-1:0] rfsh_cnt;
    logic          in_range;
    logic          term_rd, term_wr;

    logic [31:0] mem [2**MEM_AW];

    assign in_range = (addr_q >> MEM_AW) == '0;
    assign term_wr  = (state == ST_TERM) && in_range && we_q;
    assign term_rd  = (state == ST_TERM) && in_range && !we_q;
    assign busy_o   = (state != ST_IDLE);

    // tmr is shared: wait-state countdown in WAIT, stall countdown in REFRESH
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        accept    = 1'b0;
        rfsh_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rfsh_pend) begin
                    state_nxt = ST_REFRESH;
                    tmr_nxt   = 8'(REFRESH_CYCLES - 1);
                end else if (cyc_i && stb_i) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                    tmr_nxt   = 8'(WAIT_STATES);
                end
            end
            ST_WAIT: begin
                if (!cyc_i)
                    state_nxt = ST_IDLE;
                else if (tmr == 8'd0)
                    state_nxt = ST_TERM;
                else
                    tmr_nxt = tmr - 8'd1;
            end
            ST_TERM: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (!stb_i)
                    state_nxt = ST_IDLE;
            end
            ST_REFRESH: begin
                if (tmr == 8'd0) begin
                    state_nxt = ST_IDLE;
                    rfsh_done = 1'b1;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ST_IDLE;
            tmr    <= 8'd0;
            addr_q <= '0;
            wdat_q <= '0;
            we_q   <= 1'b0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            dat_o  <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (accept) begin
                addr_q <= addr_i;
                wdat_q <= dat_i;
                we_q   <= we_i;
            end
            ack_o <= (state == ST_TERM) && in_range;
            err_o <= (state == ST_TERM) && !in_range;
            if (term_rd)
                dat_o <= mem[addr_q[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (term_wr)
            mem[addr_q[MEM_AW-1:0]] <= wdat_q;
    end

    // A new period wins over a same-cycle service so that period is not lost
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rfsh_cnt  <= '0;
            rfsh_pend <= 1'b0;
        end else if (REFRESH_PERIOD != 0) begin
            if (rfsh_cnt == RP_LAST) begin
                rfsh_cnt  <= '0;
                rfsh_pend <= 1'b1;
            end else begin
                rfsh_cnt <= rfsh_cnt + 1'b1;
                if (rfsh_done)
                    rfsh_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_sdram_emulator.sv
// Bench for wb_sdram_emulator: one instance without refresh, one with a short refresh period,
// both driven with random transactions and compared against a behavioural model.
module tb_wb_sdram_emulator;

    localparam int WS  = 2;
    localparam int RP  = 20;
    localparam int RC  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] addr_s [2];
    logic [31:0] wdat_s [2];
    logic [31:0] rdat_s [2];
    logic [1:0]  we_s  = '0;
    logic [1:0]  stb_s = '0;
    logic [1:0]  cyc_s = '0;
    logic [1:0]  ack_s;
    logic [1:0]  err_s;
    logic [1:0]  busy_s;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    logic [31:0] mem_m   [2][1024];
    logic [31:0] last_rd [2];
    logic [31:0] last_btrace;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    wb_sdram_emulator #(.MEM_AW(10), .WAIT_STATES(WS), .REFRESH_PERIOD(0), .REFRESH_CYCLES(RC)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr_s[0]), .dat_i(wdat_s[0]), .dat_o(rdat_s[0]),
        .we_i(we_s[0]), .stb_i(stb_s[0]), .cyc_i(cyc_s[0]), .ack_o(ack_s[0]), .err_o(err_s[0]),
        .busy_o(busy_s[0])
    );

    wb_sdram_emulator #(.MEM_AW(10), .WAIT_STATES(WS), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr_s[1]), .dat_i(wdat_s[1]), .dat_o(rdat_s[1]),
        .we_i(we_s[1]), .stb_i(stb_s[1]), .cyc_i(cyc_s[1]), .ack_o(ack_s[1]), .err_o(err_s[1]),
        .busy_o(busy_s[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; drives a request, waits for termination, optionally keeps stb high.
    task automatic xfer(input int idx, input bit we, input logic [21:0] a, input logic [31:0] d,
                        input int hold, output logic [31:0] rd, output int lat,
                        output bit got_ack, output bit got_err, output int nterm);
        bit done = 0;
        rd = rdat_s[idx];
        lat = 0; got_ack = 0; got_err = 0; nterm = 0;
        last_btrace = '0;
        cyc_s[idx] = 1'b1; stb_s[idx] = 1'b1; we_s[idx] = we;
        addr_s[idx] = a; wdat_s[idx] = d;
        for (int i = 1; i <= 100 && !done; i++) begin
            @(negedge clk);
            if (i < 32) last_btrace[i] = busy_s[idx];
            if (ack_s[idx] || err_s[idx]) begin
                done = 1; lat = i; got_ack = ack_s[idx]; got_err = err_s[idx];
                rd = rdat_s[idx]; nterm = 1;
            end
        end
        check("xfer_timeout", 32'(done), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ack_s[idx] || err_s[idx]) nterm++;
            check("hold_busy", 32'(busy_s[idx]), 32'd1);
        end
        cyc_s[idx] = 1'b0; stb_s[idx] = 1'b0;
        @(negedge clk);
        if (ack_s[idx] || err_s[idx]) nterm++;
        check("busy_release", 32'(busy_s[idx]), 32'd0);
        @(negedge clk);
        if (ack_s[idx] || err_s[idx]) nterm++;
    endtask

    task automatic run_xfer(input int idx, input bit we, input logic [21:0] a,
                            input logic [31:0] d, input int hold, input int exp_lat);
        logic [31:0] rd;
        int lat, nterm;
        bit ga, ge;
        bit inr = (a < 22'd1024);
        xfer(idx, we, a, d, hold, rd, lat, ga, ge, nterm);
        check("term_kind", {30'd0, ga, ge}, inr ? 32'd2 : 32'd1);
        check("latency", lat, exp_lat);
        check("term_count", nterm, 32'd1);
        if (inr && we)  mem_m[idx][a[9:0]] = d;
        if (inr && !we) last_rd[idx] = mem_m[idx][a[9:0]];
        check(we ? "dat_o_hold" : (inr ? "read_data" : "err_dat_o"), rd, last_rd[idx]);
    endtask

    // Refresh-instance transaction at a chosen phase within the refresh period.
    task automatic run_r(input bit we, input logic [21:0] a, input logic [31:0] d, input int force_q);
        int q = (force_q >= 0) ? force_q : int'($urandom_range(0, 13));
        int n = 0;
        int el;
        while (!(edge_cnt >= RP && (edge_cnt % RP) == q) && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("phase_wait", 32'(n < 80), 32'd1);
        // pending set at edge (edge_cnt - q); stall ends and request is taken RC+2 edges later
        el = (q <= RC) ? (RC + 6 - q) : (3 + WS);
        run_xfer(1, we, a, d, 0, el);
    endtask

    function automatic logic [21:0] oor_addr();
        logic [11:0] hi = 12'($urandom_range(1, 4095));
        logic [9:0]  lo = 10'($urandom_range(0, 31));
        return {hi, lo};
    endfunction

    initial begin
        int nterm;
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            addr_s[k] = '0; wdat_s[k] = '0; last_rd[k] = '0;
        end

        // reset values while rst_n is low
        #23;
        for (int k = 0; k < 2; k++) begin
            check("rst_ack",  32'(ack_s[k]),  32'd0);
            check("rst_err",  32'(err_s[k]),  32'd0);
            check("rst_busy", 32'(busy_s[k]), 32'd0);
            check("rst_dat",  rdat_s[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed: write then read 0x00005
        run_xfer(0, 1'b1, 22'h00005, 32'hDEADBEEF, 0, 3 + WS);
        run_xfer(0, 1'b0, 22'h00005, 32'h0, 0, 3 + WS);

        // prefill words 0..31 with random data
        for (int i = 0; i < 32; i++)
            run_xfer(0, 1'b1, 22'(i), $urandom, 0, 3 + WS);

        // stb held five cycles past ack: one termination, stays busy
        run_xfer(0, 1'b1, 22'h00003, 32'h13579BDF, 5, 3 + WS);
        run_xfer(0, 1'b0, 22'h00003, 32'h0, 0, 3 + WS);

        // out of range: error, dat_o kept, no alias onto word 0
        run_xfer(0, 1'b0, 22'h00400, 32'h0, 0, 3 + WS);
        run_xfer(0, 1'b1, 22'h00400, 32'hA5A5A5A5, 0, 3 + WS);
        run_xfer(0, 1'b0, 22'h00000, 32'h0, 0, 3 + WS);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_xfer(0, 1'($urandom), oor_addr(), $urandom, int'($urandom_range(0, 3)), 3 + WS);
            else
                run_xfer(0, 1'($urandom), 22'($urandom_range(0, 31)), $urandom,
                         int'($urandom_range(0, 3)), 3 + WS);
        end

        // cyc dropped during WAIT
        cyc_s[0] = 1'b1; stb_s[0] = 1'b1; we_s[0] = 1'b1;
        addr_s[0] = 22'h00009; wdat_s[0] = ~mem_m[0][9];
        repeat (2) @(negedge clk);
        cyc_s[0] = 1'b0; stb_s[0] = 1'b0;
        nterm = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_s[0] || err_s[0]) nterm++;
        end
        check("abort_term", nterm, 32'd0);
        check("abort_busy", 32'(busy_s[0]), 32'd0);
        run_xfer(0, 1'b0, 22'h00009, 32'h0, 0, 3 + WS);

        // refresh instance: request on the cycle pending sets
        run_r(1'b1, 22'h00001, 32'hCAFEF00D, 0);
        check("rfsh_busy_stall", 32'(last_btrace[8:1]), 32'hFF);
        check("rfsh_idle_gap", 32'(last_btrace[9]), 32'd0);
        for (int i = 0; i < 4; i++)
            run_r(1'b1, 22'(i), $urandom, -1);
        for (int i = 0; i < 16; i++)
            run_r(1'($urandom), 22'($urandom_range(0, 3)), $urandom, -1);
        run_r(1'b0, oor_addr(), 32'h0, -1);

        // async reset in the middle of a write's WAIT
        v = mem_m[0][7];
        run_xfer(0, 1'b0, 22'h00007, 32'h0, 0, 3 + WS);
        cyc_s[0] = 1'b1; stb_s[0] = 1'b1; we_s[0] = 1'b1;
        addr_s[0] = 22'h00007; wdat_s[0] = ~v;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack",  32'(ack_s[0]),  32'd0);
        check("arst_err",  32'(err_s[0]),  32'd0);
        check("arst_busy", 32'(busy_s[0]), 32'd0);
        check("arst_dat",  rdat_s[0], 32'd0);
        cyc_s[0] = 1'b0; stb_s[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        run_xfer(0, 1'b0, 22'h00007, 32'h0, 0, 3 + WS);
        check("arst_word_kept", mem_m[0][7], v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
